// File: rtl/shift_mult8.sv
// Free-running unsigned WIDTH x WIDTH shift-and-add multiplier.
// Repeats LOAD -> CALC (WIDTH cycles) -> DONE, publishing a 2*WIDTH-bit product every WIDTH+2 cycles.
module shift_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               sig,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;

  // Upper half plus (optionally) the multiplicand; the carry bit is kept and
  // shifted back in so the accumulator never overflows.
  assign w_addend = r_acc[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  always_ff @(posedge clk or posedge sig) begin
    if (sig) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  w_next = S_CALC;
      S_CALC:  w_next = (r_cnt == LAST) ? S_DONE : S_CALC;
      S_DONE:  w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge sig) begin
    if (sig) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      out     <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_mcand <= ina;
          r_acc   <= {{WIDTH{1'b0}}, inb};
          r_cnt   <= '0;
        end
        S_CALC: begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE:  out <= r_acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_mult8.sv
// Self-checking bench for shift_mult8: scoreboard queue of a*b products,
// popped at each expected DONE; also checks reset, hold and abort behaviour.
module tb_shift_mult8;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           sig = 1'b1;
  logic [W-1:0]   ina = '0;
  logic [W-1:0]   inb = '0;
  logic [2*W-1:0] out;

  int             n_cmp = 0;
  int             n_err = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] last_out = '0;

  shift_mult8 #(.WIDTH(W)) dut (
    .clk (clk),
    .sig (sig),
    .ina (ina),
    .inb (inb),
    .out (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at the negedge just before a LOAD edge; returns at the negedge
  // following DONE (i.e. just before the next LOAD edge).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int sw_cyc, input logic [W-1:0] sa, input logic [W-1:0] sb);
    logic [2*W-1:0] exp;
    ina = a;
    inb = b;
    sb_q.push_back({8'd0, a} * {8'd0, b});
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == sw_cyc) begin
        ina = sa;
        inb = sb;
      end
      if (c < W + 2) chk("hold", out, last_out);
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      exp = sb_q.pop_front();
      chk("product", out, exp);
      last_out = exp;
    end
  endtask

  initial begin
    ina = 8'h12;
    inb = 8'h34;
    // reset held: output stays 0 across edges
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold", out, 0);
    end
    sig = 1'b0;

    // basic, repeating
    do_op(8'd13, 8'd11, 0, 0, 0);
    chk("basic_143", out, 16'h008F);
    do_op(8'd13, 8'd11, 0, 0, 0);
    do_op(8'd13, 8'd11, 0, 0, 0);

    // bounds
    do_op(8'd255, 8'd255, 0, 0, 0);
    chk("max_FE01", out, 16'hFE01);
    do_op(8'd0, 8'd200, 0, 0, 0);
    do_op(8'd1, 8'd255, 0, 0, 0);
    do_op(8'd128, 8'd2, 0, 0, 0);
    do_op(8'd200, 8'd0, 0, 0, 0);
    do_op(8'd255, 8'd1, 0, 0, 0);

    // inputs change three cycles after LOAD: current op unaffected
    do_op(8'd7, 8'd9, 3, 8'd3, 8'd3);
    do_op(8'd3, 8'd3, 0, 0, 0);

    // abort mid-CALC with a nonzero output on display
    do_op(8'd200, 8'd150, 0, 0, 0);
    ina = 8'd99;
    inb = 8'd77;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2 sig = 1'b1;
    #1 chk("rst_async", out, 0);
    last_out = '0;
    @(negedge clk);
    chk("rst_mid", out, 0);
    sig = 1'b0;
    do_op(8'd21, 8'd6, 0, 0, 0);
    chk("post_abort", out, 16'd126);

    // randomized
    for (int i = 0; i < 1000; i++)
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
